dcol_arbiter: RTL

//  Round-robin arbiter and sequencer between the 32 double-column readers and the shared output FIFO.
//  It replaces the wired-OR address bus: each cycle it grants at most one pending reader.
//  It tags the reader's 19-bit hit word with the 5-bit column id and writes the 24-bit result to the FIFO.

---
 rtl/dcol_arbiter_pkg.sv | 15 +
 rtl/dcol_arbiter_rr_pick.sv | 29 ++
 rtl/dcol_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/dcol_arbiter_pkg.sv
// Shared constants and FSM encoding for the double-column readout arbiter.
package mps_pkg;

  localparam int unsigned NCOL    = 32;
  localparam int unsigned AW      = 19;
  localparam int unsigned CW      = 5;
  localparam int unsigned FIFO_DW = CW + AW;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dcol_arbiter_rr_pick.sv
// Rotate-priority encoder: first set request at or above ptr, wrapping to index 0.
module rr_pick #(
  parameter int unsigned NCOL = mps_pkg::NCOL,
  parameter int unsigned CW   = mps_pkg::CW
) (
  input  logic [NCOL-1:0] req,
  input  logic [CW-1:0]   ptr,
  output logic [NCOL-1:0] gnt_onehot,
  output logic [CW-1:0]   gnt_idx,
  output logic            any
);
  import mps_pkg::*;

  assign any = |req;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    for (int unsigned i = 0; i < NCOL; i++) begin
      logic [CW-1:0] j;
      j = CW'((32'(ptr) + i) % NCOL);
      if ((gnt_onehot == '0) && req[j]) begin
        gnt_onehot[j] = 1'b1;
        gnt_idx       = j;
      end
    end
  end

endmodule

// File: rtl/dcol_arbiter.sv
// Round-robin arbiter between the double-column readers and the shared output FIFO;
// tags each granted hit word with its column id and writes it one cycle after the grant decision.
module dcol_arbiter #(
  parameter int unsigned NCOL = mps_pkg::NCOL,
  parameter int unsigned AW   = mps_pkg::AW,
  parameter int unsigned CW   = mps_pkg::CW,
  parameter int unsigned CNTW = 16
) (
  input  logic                 clk2,
  input  logic                 sys_reset,
  input  logic                 arb_en,
  input  logic                 flush,
  input  logic [NCOL-1:0]      dcol_req,
  input  logic [NCOL*AW-1:0]   dcol_addr,
  input  logic                 fifo_full,
  output logic [NCOL-1:0]      dcol_grant,
  output logic                 fifo_wr,
  output logic [CW+AW-1:0]     fifo_data,
  output logic                 busy,
  output logic                 flush_done,
  output logic [CNTW-1:0]      word_cnt
);
  import mps_pkg::*;

  arb_state_e       state_q, state_d;
  logic [CW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NCOL-1:0]  gnt_q, gnt_d;
  logic             wr_q, wr_d;
  logic [CW+AW-1:0] data_q, data_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic [NCOL-1:0]  elig;
  logic [NCOL-1:0]  pick_oh;
  logic [CW-1:0]    pick_idx;
  logic             pick_any;
  logic             arb_active;
  logic             do_grant;
  logic             drained;
  logic [AW-1:0]    words [NCOL];

  for (genvar k = 0; k < NCOL; k++) begin : g_unpack
    assign words[k] = dcol_addr[k*AW +: AW];
  end

  // The reader granted last cycle still shows its popped word; keep it out of this round.
  assign elig = dcol_req & ~gnt_q;

  rr_pick #(
    .NCOL (NCOL),
    .CW   (CW)
  ) u_pick (
    .req        (elig),
    .ptr        (rr_ptr_q),
    .gnt_onehot (pick_oh),
    .gnt_idx    (pick_idx),
    .any        (pick_any)
  );

  assign arb_active = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign do_grant   = arb_active && pick_any && !fifo_full;
  assign drained    = !pick_any && !wr_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (flush)       state_d = ST_FLUSH;
        else if (arb_en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (flush)        state_d = ST_FLUSH;
        else if (!arb_en) state_d = ST_IDLE;
      end
      ST_FLUSH: begin
        if (drained) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_d    = '0;
    wr_d     = 1'b0;
    data_d   = data_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    if (do_grant) begin
      gnt_d    = pick_oh;
      wr_d     = 1'b1;
      data_d   = {pick_idx, words[pick_idx]};
      rr_ptr_d = (pick_idx == CW'(NCOL - 1)) ? '0 : pick_idx + 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk2 or posedge sys_reset) begin
    if (sys_reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      wr_q     <= 1'b0;
      data_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      wr_q     <= wr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dcol_grant = gnt_q;
  assign fifo_wr    = wr_q;
  assign fifo_data  = data_q;
  assign busy       = (state_q != ST_IDLE);
  assign flush_done = (state_q == ST_FLUSH) && drained;
  assign word_cnt   = cnt_q;

endmodule
